data_mem_arbiter: RTL and testbench

- Two-requester controller in front of the single-port, word-wide data memory.
- Port 0 is the CPU load/store unit. Port 1 is the loader/DMA/debug master.
- Round-robin arbitration, valid/ready request handshake, one-cycle response pulse.
- Adds byte/halfword access on top of the word-only memory: loads are extracted with sign/zero extension; sub-word stores go through a read-modify-write sequence.

---
 rtl/data_mem_arb_pkg.sv | 39 +++
 rtl/mem_lane_align.sv | 60 ++++++
 rtl/data_mem_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the two-port data memory arbiter.
//   size_e  : access size encoding carried on req_size
//   state_e : arbiter FSM states
//   NUM_PORTS, bswap32, access_bytes
package data_mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RMW_WR = 2'b10
    } state_e;

    // The memory write port is big-endian by lane while the read port and
    // the requesters are little-endian; this swaps between the two views.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Number of bytes touched by an access; the illegal size reports a word
    // so that the range check stays meaningful (it is flagged anyway).
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment between sub-word requests and the
// little-endian memory read word.
//   rdata/offset/size/is_unsigned -> load_data : extracted and extended load
//   old_word/wdata/offset/size    -> merged    : old word with new lanes merged
module mem_lane_align
    import data_mem_arb_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] mask_s;

    assign shamt_s = {offset, 3'b000};

    // Select the addressed byte and halfword lanes of the read word.
    always_comb begin
        case (offset)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = 8'h00;
        endcase
        if (offset[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign- or zero-extend the selected lanes into the load result.
    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & byte_s[7]}}, byte_s};
            SZ_HALF: load_data = {{16{~is_unsigned & half_s[15]}}, half_s};
            default: load_data = rdata;
        endcase
    end

    // Replace only the written lanes of the old word with the shifted store data.
    always_comb begin
        case (size)
            SZ_BYTE: mask_s = 32'h0000_00FF << shamt_s;
            SZ_HALF: mask_s = 32'h0000_FFFF << shamt_s;
            default: mask_s = 32'hFFFF_FFFF;
        endcase
        merged = (old_word & ~mask_s) | ((wdata << shamt_s) & mask_s);
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin two-port controller in front of a single-port word memory.
// Port 0 is the CPU load/store unit, port 1 the loader/DMA/debug master.
// Adds byte/half accesses: loads are lane-extracted and extended, sub-word
// stores go through a read-modify-write (ACCESS reads, RMW_WR writes).
//   req_*       : per-port valid/ready request (bit/element i = port i)
//   resp_*      : per-port one-cycle response pulse with error and load data
//   mem_*       : word-aligned memory port; write lanes big-endian, read
//                 lanes little-endian
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 32,
    parameter logic [31:0] MEM_BYTES     = 32'h0002_0000
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_PORTS-1:0]                    req_valid,
    output logic [NUM_PORTS-1:0]                    req_ready,
    input  logic [NUM_PORTS-1:0]                    req_we,
    input  logic [NUM_PORTS-1:0][1:0]               req_size,
    input  logic [NUM_PORTS-1:0]                    req_unsigned,
    input  logic [NUM_PORTS-1:0][ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_PORTS-1:0]                    resp_valid,
    output logic [NUM_PORTS-1:0]                    resp_err,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]    resp_rdata,
    output logic                                    mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]                   mem_wdata,
    input  logic [DATA_WIDTH-1:0]                   mem_rdata
);

    state_e                               state_r;
    state_e                               state_nxt_s;
    logic                                 last_grant_r;
    logic                                 winner_s;
    logic [NUM_PORTS-1:0]                 ready_s;
    logic                                 accept_s;

    logic [1:0]                           sel_size_s;
    logic [ADDRESS_WIDTH-1:0]             sel_addr_s;
    logic [ADDRESS_WIDTH:0]               end_addr_s;
    logic                                 align_err_s;
    logic                                 range_err_s;
    logic                                 sel_err_s;

    logic                                 cur_port_r;
    logic                                 cur_we_r;
    logic                                 cur_uns_r;
    logic                                 cur_err_r;
    logic [1:0]                           cur_size_r;
    logic [ADDRESS_WIDTH-1:0]             cur_addr_r;
    logic [DATA_WIDTH-1:0]                cur_wdata_r;

    logic [DATA_WIDTH-1:0]                load_data_s;
    logic [DATA_WIDTH-1:0]                merged_s;

    logic                                 mem_wr_en_r;
    logic [ADDRESS_WIDTH-1:0]             mem_addr_r;
    logic [DATA_WIDTH-1:0]                mem_wdata_r;
    logic [NUM_PORTS-1:0]                 resp_valid_r;
    logic [NUM_PORTS-1:0]                 resp_err_r;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] resp_rdata_r;

    logic                                 mem_wr_en_nxt_s;
    logic [ADDRESS_WIDTH-1:0]             mem_addr_nxt_s;
    logic [DATA_WIDTH-1:0]                mem_wdata_nxt_s;
    logic [NUM_PORTS-1:0]                 resp_valid_nxt_s;
    logic [NUM_PORTS-1:0]                 resp_err_nxt_s;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] resp_rdata_nxt_s;

    assign req_ready  = ready_s;
    assign accept_s   = |ready_s;
    assign mem_wr_en  = mem_wr_en_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign resp_valid = resp_valid_r;
    assign resp_err   = resp_err_r;
    assign resp_rdata = resp_rdata_r;

    mem_lane_align u_lane (
        .rdata       (mem_rdata),
        .offset      (cur_addr_r[1:0]),
        .size        (cur_size_r),
        .is_unsigned (cur_uns_r),
        .old_word    (mem_rdata),
        .wdata       (cur_wdata_r),
        .load_data   (load_data_s),
        .merged      (merged_s)
    );

    // Round-robin pick: on contention the port that was not granted last wins.
    always_comb begin
        if (req_valid[0] && req_valid[1]) begin
            winner_s = ~last_grant_r;
        end else if (req_valid[1]) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // Alignment, size and range checks on the request being offered for grant.
    always_comb begin
        sel_size_s = req_size[winner_s];
        sel_addr_s = req_addr[winner_s];
        case (sel_size_s)
            SZ_BYTE: align_err_s = 1'b0;
            SZ_HALF: align_err_s = sel_addr_s[0];
            SZ_WORD: align_err_s = |sel_addr_s[1:0];
            default: align_err_s = 1'b1;
        endcase
        // One extra bit so accesses near the top of the address space cannot wrap.
        end_addr_s  = {1'b0, sel_addr_s} + {{(ADDRESS_WIDTH-2){1'b0}}, access_bytes(sel_size_s)};
        range_err_s = end_addr_s > (ADDRESS_WIDTH+1)'(MEM_BYTES);
        sel_err_s   = align_err_s | range_err_s;
    end

    // Next state, combinational grant and next values of the registered outputs.
    always_comb begin
        state_nxt_s      = state_r;
        ready_s          = '0;
        mem_wr_en_nxt_s  = 1'b0;
        mem_addr_nxt_s   = '0;
        mem_wdata_nxt_s  = '0;
        resp_valid_nxt_s = '0;
        resp_err_nxt_s   = '0;
        resp_rdata_nxt_s = '0;
        case (state_r)
            IDLE: begin
                // Gated by rst so nothing is offered while reset is held.
                if ((|req_valid) && !rst) begin
                    ready_s[winner_s] = 1'b1;
                    state_nxt_s       = ACCESS;
                    mem_addr_nxt_s    = {sel_addr_s[ADDRESS_WIDTH-1:2], 2'b00};
                    if (req_we[winner_s] && (sel_size_s == SZ_WORD) && !sel_err_s) begin
                        mem_wr_en_nxt_s = 1'b1;
                        mem_wdata_nxt_s = bswap32(req_wdata[winner_s]);
                    end else begin
                        mem_wr_en_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                state_nxt_s = IDLE;
                if (cur_err_r) begin
                    resp_valid_nxt_s[cur_port_r] = 1'b1;
                    resp_err_nxt_s[cur_port_r]   = 1'b1;
                end else if (!cur_we_r) begin
                    resp_valid_nxt_s[cur_port_r] = 1'b1;
                    resp_rdata_nxt_s[cur_port_r] = load_data_s;
                end else if (cur_size_r == SZ_WORD) begin
                    resp_valid_nxt_s[cur_port_r] = 1'b1;
                end else begin
                    // Sub-word store: the merge result is held in mem_wdata for the write cycle.
                    state_nxt_s     = RMW_WR;
                    mem_wr_en_nxt_s = 1'b1;
                    mem_addr_nxt_s  = mem_addr_r;
                    mem_wdata_nxt_s = bswap32(merged_s);
                end
            end
            RMW_WR: begin
                state_nxt_s                  = IDLE;
                resp_valid_nxt_s[cur_port_r] = 1'b1;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                last_grant_r <= winner_s;
            end
        end
    end

    // Capture the accepted request for the rest of the transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_port_r  <= 1'b0;
            cur_we_r    <= 1'b0;
            cur_uns_r   <= 1'b0;
            cur_err_r   <= 1'b0;
            cur_size_r  <= 2'b00;
            cur_addr_r  <= '0;
            cur_wdata_r <= '0;
        end else if (accept_s) begin
            cur_port_r  <= winner_s;
            cur_we_r    <= req_we[winner_s];
            cur_uns_r   <= req_unsigned[winner_s];
            cur_err_r   <= sel_err_s;
            cur_size_r  <= sel_size_s;
            cur_addr_r  <= sel_addr_s;
            cur_wdata_r <= req_wdata[winner_s];
        end
    end

    // Registered memory and response outputs; async reset kills any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr_en_r  <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= '0;
            resp_valid_r <= '0;
            resp_err_r   <= '0;
            resp_rdata_r <= '0;
        end else begin
            mem_wr_en_r  <= mem_wr_en_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            mem_wdata_r  <= mem_wdata_nxt_s;
            resp_valid_r <= resp_valid_nxt_s;
            resp_err_r   <= resp_err_nxt_s;
            resp_rdata_r <= resp_rdata_nxt_s;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a byte-array
// memory model (big-endian write lanes, little-endian read lanes).
module tb_data_mem_arbiter;

    logic              clk;
    logic              rst;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0]        req_we;
    logic [1:0][1:0]   req_size;
    logic [1:0]        req_unsigned;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        resp_valid;
    logic [1:0]        resp_err;
    logic [1:0][31:0]  resp_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [7:0]        tmem [0:4095];
    logic              pl_en;
    logic [11:0]       pl_addr;
    logic [7:0]        pl_data;
    logic [11:0]       ridx;
    logic [11:0]       widx;

    int                total;
    int                bad;

    logic [1:0]        r_rdy;
    int                r_lat;
    logic [1:0]        r_rv;
    logic [1:0]        r_re;
    logic [31:0]       r_rd;
    int                r_nwr;
    int                r_wcyc;
    logic [31:0]       r_waddr;
    logic [31:0]       r_wdat;

    logic [1:0]        grants [0:7];
    logic [1:0]        rsps [0:7];
    int                ng;
    int                nr;
    int                seen;

    data_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_wr_en    (mem_wr_en),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model read port: byte addr+0 on [7:0].
    always_comb begin
        ridx      = mem_addr[11:0];
        mem_rdata = {tmem[ridx + 12'd3], tmem[ridx + 12'd2], tmem[ridx + 12'd1], tmem[ridx]};
    end

    // Memory model write port (byte addr+0 on [31:24]) plus bench preload port.
    always @(posedge clk) begin
        widx = mem_addr[11:0];
        if (pl_en) tmem[pl_addr] <= pl_data;
        if (mem_wr_en) begin
            tmem[widx]          <= mem_wdata[31:24];
            tmem[widx + 12'd1]  <= mem_wdata[23:16];
            tmem[widx + 12'd2]  <= mem_wdata[15:8];
            tmem[widx + 12'd3]  <= mem_wdata[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pl_write(input logic [11:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    // Offer one request on port p, then follow it to its response (bounded).
    task automatic do_access(input logic p, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid       = 2'b00;
        req_valid[p]    = 1'b1;
        req_we[p]       = we;
        req_size[p]     = size;
        req_unsigned[p] = uns;
        req_addr[p]     = addr;
        req_wdata[p]    = wdata;
        r_lat = 0; r_rv = 2'b00; r_re = 2'b00; r_rd = 32'h0000_0000;
        r_nwr = 0; r_wcyc = 0; r_waddr = 32'h0000_0000; r_wdat = 32'h0000_0000;
        #1;
        r_rdy = req_ready;
        tick();
        req_valid = 2'b00;
        for (int k = 1; k <= 6; k++) begin
            if (mem_wr_en) begin
                r_nwr++;
                r_wcyc  = k;
                r_waddr = mem_addr;
                r_wdat  = mem_wdata;
            end
            if (resp_valid != 2'b00) begin
                r_lat = k;
                r_rv  = resp_valid;
                r_re  = resp_err;
                r_rd  = resp_rdata[p];
                break;
            end
            tick();
        end
    endtask

    task automatic check_resp(input string tag, input logic p, input int elat,
                              input logic eerr, input logic [31:0] erd, input int enwr);
        logic [1:0] oh;
        oh = p ? 2'b10 : 2'b01;
        chk({tag, "_ready"}, {30'd0, r_rdy}, {30'd0, oh});
        chk({tag, "_lat"}, 32'(r_lat), 32'(elat));
        chk({tag, "_rvalid"}, {30'd0, r_rv}, {30'd0, oh});
        chk({tag, "_rerr"}, {30'd0, r_re}, eerr ? {30'd0, oh} : 32'd0);
        chk({tag, "_rdata"}, r_rd, erd);
        chk({tag, "_nwr"}, 32'(r_nwr), 32'(enwr));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst          = 1'b1;
        pl_en        = 1'b0;
        pl_addr      = 12'h000;
        pl_data      = 8'h00;
        req_valid    = 2'b11;
        req_we       = 2'b00;
        req_size     = {2'b10, 2'b10};
        req_unsigned = 2'b00;
        req_addr     = {32'h0000_0100, 32'h0000_0100};
        req_wdata    = {32'h0000_0000, 32'h0000_0000};

        pl_write(12'h100, 8'h11);
        pl_write(12'h101, 8'h22);
        pl_write(12'h102, 8'h33);
        pl_write(12'h103, 8'h44);

        // Reset state, with both requests offered while reset is held.
        chk("rst_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rvalid", {30'd0, resp_valid}, 32'd0);
        chk("rst_rerr", {30'd0, resp_err}, 32'd0);
        chk("rst_rdata0", resp_rdata[0], 32'h0000_0000);
        chk("rst_rdata1", resp_rdata[1], 32'h0000_0000);
        chk("rst_wren", {31'd0, mem_wr_en}, 32'd0);
        chk("rst_maddr", mem_addr, 32'h0000_0000);
        chk("rst_mwdata", mem_wdata, 32'h0000_0000);
        req_valid = 2'b00;
        rst       = 1'b0;
        tick();

        // Word load.
        do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000);
        check_resp("wload", 1'b0, 2, 1'b0, 32'h4433_2211, 0);

        // Signed / unsigned sub-word loads.
        pl_write(12'h101, 8'h92);
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_0000);
        check_resp("sbyte", 1'b1, 2, 1'b0, 32'hFFFF_FF92, 0);
        do_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0000_0000);
        check_resp("ubyte", 1'b1, 2, 1'b0, 32'h0000_0092, 0);
        do_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0000_0000);
        check_resp("uhalf", 1'b1, 2, 1'b0, 32'h0000_4433, 0);
        do_access(1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0000_0000);
        check_resp("shalf", 1'b0, 2, 1'b0, 32'hFFFF_9211, 0);

        // Byte store via read-modify-write.
        pl_write(12'h101, 8'h22);
        do_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_00AB);
        check_resp("bstore", 1'b0, 3, 1'b0, 32'h0000_0000, 1);
        chk("bstore_wcyc", 32'(r_wcyc), 32'd2);
        chk("bstore_waddr", r_waddr, 32'h0000_0100);
        chk("bstore_wdata", r_wdat, 32'h1122_AB44);
        do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000);
        check_resp("wload2", 1'b0, 2, 1'b0, 32'h44AB_2211, 0);

        // Word store, then half store into the same word, then read back.
        do_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF);
        check_resp("wstore", 1'b1, 2, 1'b0, 32'h0000_0000, 1);
        chk("wstore_wcyc", 32'(r_wcyc), 32'd1);
        chk("wstore_waddr", r_waddr, 32'h0000_0104);
        chk("wstore_wdata", r_wdat, 32'hEFBE_ADDE);
        do_access(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0106, 32'h0000_1234);
        check_resp("hstore", 1'b1, 3, 1'b0, 32'h0000_0000, 1);
        chk("hstore_wdata", r_wdat, 32'hEFBE_3412);
        do_access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0000_0000);
        check_resp("wload3", 1'b0, 2, 1'b0, 32'h1234_BEEF, 0);

        // Error cases and range boundaries.
        do_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0000_5555);
        check_resp("err_half", 1'b0, 2, 1'b1, 32'h0000_0000, 0);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0000_0000);
        check_resp("err_word", 1'b1, 2, 1'b1, 32'h0000_0000, 0);
        do_access(1'b0, 1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0000_0000);
        check_resp("err_size", 1'b0, 2, 1'b1, 32'h0000_0000, 0);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0001_FFFE, 32'h0000_0000);
        check_resp("err_top", 1'b1, 2, 1'b1, 32'h0000_0000, 0);
        do_access(1'b0, 1'b0, 2'b00, 1'b0, 32'h0002_0000, 32'h0000_0000);
        check_resp("err_range", 1'b0, 2, 1'b1, 32'h0000_0000, 0);
        do_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0002_0000, 32'h1111_1111);
        check_resp("err_wst", 1'b0, 2, 1'b1, 32'h0000_0000, 0);
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0001_FFFC, 32'h0000_0000);
        chk("ok_lastword_err", {30'd0, r_re}, 32'd0);
        chk("ok_lastword_lat", 32'(r_lat), 32'd2);
        do_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0001_FFFF, 32'h0000_0000);
        chk("ok_lastbyte_err", {30'd0, r_re}, 32'd0);

        // Arbitration from reset with both ports always requesting.
        rst = 1'b1;
        tick();
        req_we       = 2'b00;
        req_size     = {2'b10, 2'b10};
        req_unsigned = 2'b00;
        req_addr     = {32'h0000_0104, 32'h0000_0100};
        req_valid    = 2'b11;
        rst          = 1'b0;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (req_ready != 2'b00 && ng < 8) begin
                grants[ng] = req_ready;
                ng++;
            end
            if (resp_valid != 2'b00 && nr < 8) begin
                rsps[nr] = resp_valid;
                nr++;
            end
            tick();
        end
        req_valid = 2'b00;
        chk("arb_ngrant", 32'(ng), 32'd4);
        chk("arb_g0", {30'd0, grants[0]}, 32'd1);
        chk("arb_g1", {30'd0, grants[1]}, 32'd2);
        chk("arb_g2", {30'd0, grants[2]}, 32'd1);
        chk("arb_g3", {30'd0, grants[3]}, 32'd2);
        chk("arb_nresp", 32'(nr), 32'd3);
        chk("arb_r0", {30'd0, rsps[0]}, 32'd1);
        chk("arb_r1", {30'd0, rsps[1]}, 32'd2);
        tick();
        do_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0000_0000);
        check_resp("p1_alone", 1'b1, 2, 1'b0, 32'h1234_BEEF, 0);

        // Reset in the middle of a read-modify-write.
        req_valid       = 2'b01;
        req_we[0]       = 1'b1;
        req_size[0]     = 2'b00;
        req_unsigned[0] = 1'b0;
        req_addr[0]     = 32'h0000_0100;
        req_wdata[0]    = 32'h0000_0055;
        #1;
        chk("rmwrst_ready", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        chk("rmwrst_acc_wren", {31'd0, mem_wr_en}, 32'd0);
        tick();
        chk("rmwrst_wr_wren", {31'd0, mem_wr_en}, 32'd1);
        chk("rmwrst_wr_wdata", mem_wdata, 32'h5522_AB44);
        rst = 1'b1;
        #1;
        chk("rmwrst_wren_drop", {31'd0, mem_wr_en}, 32'd0);
        chk("rmwrst_rvalid", {30'd0, resp_valid}, 32'd0);
        chk("rmwrst_maddr", mem_addr, 32'h0000_0000);
        tick();
        rst = 1'b0;
        chk("rmwrst_mem", {24'd0, tmem[12'h100]}, 32'h0000_0011);
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            if (resp_valid != 2'b00) seen++;
            tick();
        end
        chk("rmwrst_noresp", 32'(seen), 32'd0);
        req_we       = 2'b00;
        req_size     = {2'b10, 2'b10};
        req_addr     = {32'h0000_0104, 32'h0000_0100};
        req_valid    = 2'b11;
        #1;
        chk("rmwrst_next_grant", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid = 2'b00;
        tick();
        chk("rmwrst_next_resp", {30'd0, resp_valid}, 32'd1);
        chk("rmwrst_next_rdata", resp_rdata[0], 32'h44AB_2211);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
